// File: rtl/cc_fill_seq.sv
// Cache-line fill sequencer: gathers four fill beats, writes the line as two half-line cycles, and issues line invalidates.
// Latency: beat-3 acceptance at edge N gives the low-half write in cycle N..N+1, the high half plus fill_done in the next cycle.
// Backpressure: fill_ready is high only in IDLE (when no invalidate is pending) and COLLECT; it is low while rst is high.
module cc_fill_seq #(
    parameter int BEAT_W   = 260,
    parameter int IP_WIDTH = 44
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill_valid,
    input  logic                  fill_first,
    input  logic [IP_WIDTH-1:0]   fill_addr,
    input  logic [BEAT_W-1:0]     fill_data,
    output logic                  fill_ready,
    input  logic                  inv_req,
    input  logic [IP_WIDTH-1:0]   inv_IP,
    output logic                  inv_ack,
    output logic [IP_WIDTH-1:0]   write_IP,
    output logic                  cc_write_wen,
    output logic                  cc_invalidate,
    output logic [2*BEAT_W-1:0]   write_data,
    output logic                  fill_done,
    output logic                  fill_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WR_LO   = 3'd2,
        WR_HI   = 3'd3,
        INV     = 3'd4
    } state_t;

    state_t                state;
    logic [1:0]            beatCnt;
    logic [IP_WIDTH-1:0]   lineAddr;
    logic [4*BEAT_W-1:0]   lineBuf;
    logic                  beatAcc;

    // An invalidate in IDLE blocks the fill beat in the same cycle, so ready looks at inv_req directly.
    assign fill_ready = !rst && (((state == IDLE) && !inv_req) || (state == COLLECT));
    assign beatAcc    = fill_valid && fill_ready;

    // Sequencer: state, line assembly and all registered outputs; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beatCnt       <= 2'd0;
            lineAddr      <= '0;
            lineBuf       <= '0;
            write_IP      <= '0;
            write_data    <= '0;
            cc_write_wen  <= 1'b0;
            cc_invalidate <= 1'b0;
            inv_ack       <= 1'b0;
            fill_done     <= 1'b0;
            fill_err      <= 1'b0;
        end else begin
            cc_write_wen  <= 1'b0;
            cc_invalidate <= 1'b0;
            inv_ack       <= 1'b0;
            fill_done     <= 1'b0;
            fill_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (inv_req) begin
                        state         <= INV;
                        cc_invalidate <= 1'b1;
                        inv_ack       <= 1'b1;
                        write_IP      <= inv_IP;
                    end else if (beatAcc) begin
                        if (fill_first) begin
                            lineAddr                <= fill_addr;
                            lineBuf[BEAT_W-1:0]     <= fill_data;
                            beatCnt                 <= 2'd1;
                            state                   <= COLLECT;
                        end else begin
                            // A stray continuation beat is dropped and flagged.
                            fill_err <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (beatAcc) begin
                        if (fill_first) begin
                            // New line started before the old one finished: abandon the partial line.
                            fill_err                <= 1'b1;
                            lineAddr                <= fill_addr;
                            lineBuf[BEAT_W-1:0]     <= fill_data;
                            beatCnt                 <= 2'd1;
                        end else begin
                            for (int k = 0; k < 4; k++) begin
                                if (beatCnt == k[1:0]) begin
                                    lineBuf[k*BEAT_W +: BEAT_W] <= fill_data;
                                end
                            end
                            beatCnt <= beatCnt + 2'd1;
                            if (beatCnt == 2'd3) begin
                                // Low half only needs slots 0/1, already stored, so it can go out now.
                                state        <= WR_LO;
                                cc_write_wen <= 1'b1;
                                write_IP     <= lineAddr;
                                write_data   <= lineBuf[2*BEAT_W-1:0];
                            end
                        end
                    end
                end
                WR_LO: begin
                    state      <= WR_HI;
                    write_data <= lineBuf[4*BEAT_W-1:2*BEAT_W];
                    fill_done  <= 1'b1;
                end
                WR_HI: begin
                    state <= IDLE;
                end
                INV: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cc_fill_seq.md
CC_FILL_SEQ -- requirements
Module: cc_fill_seq

Interface
REQ-001 SHALL have parameter BEAT_W, default 260, meaning the width of one fill beat (a quarter of a 65*16-bit cache line).
REQ-002 SHALL have parameter IP_WIDTH, default 44, meaning the instruction-address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port fill_valid, input, 1: a fill beat is presented.
REQ-006 SHALL have port fill_first, input, 1: the presented beat is beat 0 of a line.
REQ-007 SHALL have port fill_addr, input, IP_WIDTH: line address, sampled only on an accepted first beat.
REQ-008 SHALL have port fill_data, input, BEAT_W: beat payload.
REQ-009 SHALL have port fill_ready, output, 1: the block accepts a beat this cycle.
REQ-010 SHALL have port inv_req, input, 1: line invalidate request.
REQ-011 SHALL have port inv_IP, input, IP_WIDTH: address to invalidate.
REQ-012 SHALL have port inv_ack, output, 1: one-cycle pulse, invalidate issued.
REQ-013 SHALL have port write_IP, output, IP_WIDTH: address driven to the cache write port.
REQ-014 SHALL have port cc_write_wen, output, 1: cache write strobe (low-half cycle).
REQ-015 SHALL have port cc_invalidate, output, 1: cache invalidate strobe.
REQ-016 SHALL have port write_data, output, 2*BEAT_W: half-line write data.
REQ-017 SHALL have port fill_done, output, 1: one-cycle pulse when the high half is driven.
REQ-018 SHALL have port fill_err, output, 1: one-cycle pulse on a protocol violation.

Function
REQ-019 SHALL implement FSM states IDLE, COLLECT, WR_LO, WR_HI, INV.
REQ-020 SHALL define a beat as accepted when fill_valid&fill_ready at posedge; fill_ready=1 only in IDLE and COLLECT.
REQ-021 SHALL, in IDLE with inv_req=1, go to INV, with inv_req taking priority over a simultaneous fill beat (the beat is not accepted: fill_ready=0 in that cycle, computed from inv_req).
REQ-022 SHALL, in INV (one cycle), drive cc_invalidate=1, write_IP=inv_IP captured at entry, inv_ack=1, then return to IDLE.
REQ-023 SHALL, on an accepted beat with fill_first=1 in IDLE, capture fill_addr, store the beat into slot 0, set beat counter=1, and go to COLLECT.
REQ-024 SHALL store beat k into line bits [BEAT_W*k+BEAT_W-1 : BEAT_W*k]; the 2-bit counter increments per accepted beat.
REQ-025 SHALL, on acceptance of the beat in slot 3, go to WR_LO.
REQ-026 SHALL, in WR_LO, drive cc_write_wen=1, write_IP=captured address, write_data=line[2*BEAT_W-1:0].
REQ-027 SHALL, in WR_HI (the cycle immediately after WR_LO), drive cc_write_wen=0, write_IP unchanged, write_data=line[4*BEAT_W-1:2*BEAT_W], fill_done=1, then go to IDLE.
REQ-028 SHALL keep the minimum spacing between consecutive cc_write_wen pulses at 3 cycles; a new first beat is accepted no earlier than the cycle after WR_HI.
REQ-029 SHALL hold outputs stable in all other cycles: cc_write_wen, cc_invalidate, inv_ack, fill_done, and fill_err=0; write_IP/write_data hold their last values.
REQ-030 SHALL, on an accepted beat with fill_first=0 in IDLE, discard it, pulse fill_err next cycle, and stay in IDLE.
REQ-031 SHALL, on an accepted beat with fill_first=1 in COLLECT, pulse fill_err, abandon the partial line, and restart as in REQ-023 with the new address.
REQ-032 SHALL ignore inv_req in COLLECT/WR_LO/WR_HI; inv_req is serviced when IDLE is next reached (the requester holds it until inv_ack).
REQ-033 SHALL never assert cc_write_wen and cc_invalidate in the same cycle.
REQ-034 SHALL drive all outputs except fill_ready from registers (latency: beat-3 acceptance at edge N gives cc_write_wen=1 in cycle N..N+1).

Reset
REQ-035 SHALL, with rst=1 at posedge, force IDLE, counter=0, write_IP=0, write_data=0, cc_write_wen=0, cc_invalidate=0, inv_ack=0, fill_done=0, fill_err=0; fill_ready SHALL read 0 while rst=1.
REQ-036 SHALL, on reset mid-COLLECT or mid-WR_LO, drop the partial line with no WR_HI cycle issued.

Verification
REQ-037 SHALL cover a clean fill: addr=0x0ABCDE00020, beats D0..D3 back-to-back -> wen=1 with {D1,D0} for 1 cycle, then {D3,D2} with fill_done=1, write_IP=0x0ABCDE00020 in both cycles.
REQ-038 SHALL cover a gapped fill: fill_valid low for 3 cycles between beats 1 and 2 -> same outputs as REQ-037, no early wen.
REQ-039 SHALL cover an invalidate in IDLE: inv_req with inv_IP=0x123 together with a first beat -> cc_invalidate=1, write_IP=0x123, inv_ack=1; the beat is not accepted, and the fill proceeds afterward.
REQ-040 SHALL cover a protocol error: a non-first beat in IDLE -> fill_err pulse, no wen; fill_first in COLLECT after 2 beats -> fill_err, then a complete write of the new line only.
REQ-041 SHALL cover reset on the cycle after beat-3 acceptance -> no wen or data on the following cycles, all outputs 0.
REQ-042 SHALL cover back-to-back lines: the second line's first beat offered during WR_HI -> accepted one cycle later; the wen pulses are 3 or more cycles apart.
